sda_gmem_read_arbiter: RTL and testbench

Shares the single gmem AXI4 master read channel (AR/R) between NREQ requesters inside the generated action core.
- Arbitrates read bursts round-robin and issues one AR at a time.
- Records the grant order in a small FIFO. Read data returns in order because a single ARID is used, so each R burst is routed to the requester at the FIFO head.
- The write channel and the remaining AR sideband fields (size, burst, cache, ID = 0, ...) are tied off at integration.

---
 rtl/sda_gmem_arb_pkg.sv | 22 ++
 rtl/sda_gmem_grant_fifo.sv | 73 +++++++
 rtl/sda_gmem_read_arbiter.sv | 158 +++++++++++++++
 tb/tb_sda_gmem_read_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sda_gmem_arb_pkg.sv
// Shared constants, types and helpers for the gmem read-channel arbiter.
// Widths that depend on module parameters are derived with clog2 at the use site.
package sda_gmem_arb_pkg;

  localparam int AXI_LEN_W = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } ar_state_e;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sda_gmem_grant_fifo.sv
// Grant-order FIFO: remembers which requester owns each outstanding read burst.
// Push and pop may happen in the same cycle, including when the FIFO is full.
module sda_gmem_grant_fifo
  import sda_gmem_arb_pkg::*;
#(
  parameter int GRANT_W = 1,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [GRANT_W-1:0] push_data,
  input  logic               pop,
  output logic [GRANT_W-1:0] head,
  output logic               empty,
  output logic               full
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [GRANT_W-1:0] mem_q [DEPTH];
  logic [GRANT_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign head  = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // DEPTH is a power of two, so the pointers wrap without explicit compare.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage carries no reset; validity is tracked by the counter.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/sda_gmem_read_arbiter.sv
// Round-robin sharing of one gmem AXI4 read channel among NREQ requesters.
// One AR in flight on the bus at a time; R bursts return in grant order and are steered by FIFO head.
module sda_gmem_read_arbiter
  import sda_gmem_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MAX_OUT = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ*ADDR_W-1:0]    req_araddr,
  input  logic [NREQ*AXI_LEN_W-1:0] req_arlen,
  input  logic [NREQ-1:0]           req_arvalid,
  output logic [NREQ-1:0]           req_arready,
  output logic [DATA_W-1:0]         req_rdata,
  output logic [1:0]                req_rresp,
  output logic                      req_rlast,
  output logic [NREQ-1:0]           req_rvalid,
  input  logic [NREQ-1:0]           req_rready,
  output logic [ADDR_W-1:0]         m_araddr,
  output logic [AXI_LEN_W-1:0]      m_arlen,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  input  logic [DATA_W-1:0]         m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rlast,
  input  logic                      m_rvalid,
  output logic                      m_rready
);

  localparam int GRANT_W = clog2(NREQ);
  localparam int CNT_W   = clog2(MAX_OUT) + 1;

  ar_state_e            state_q, state_d;
  logic [GRANT_W-1:0]   last_grant_q, last_grant_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]    araddr_q, araddr_d;
  logic [AXI_LEN_W-1:0] arlen_q, arlen_d;
  logic                 arvalid_q, arvalid_d;

  logic [GRANT_W-1:0]   pick;
  logic                 pick_vld;
  logic                 grant;
  logic                 pop;
  logic [GRANT_W-1:0]   head;
  logic                 fifo_empty;
  logic                 fifo_full;

  // Scan downward so the nearest requester after last_grant is written last and wins.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = last_grant_q;
    pick_vld = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last_grant_q) + k) % NREQ;
      if (req_arvalid[idx]) begin
        pick     = GRANT_W'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  // The count is compared before this cycle's pop, so a full FIFO stays blocked one extra cycle.
  assign grant = (state_q == ST_IDLE) && pick_vld &&
                 (cnt_q < CNT_W'(MAX_OUT)) && !fifo_full;
  assign pop   = m_rvalid && m_rready && m_rlast;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_W'(NREQ - 1);
      cnt_q        <= '0;
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
      arlen_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      arvalid_q    <= arvalid_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (grant) state_d = ST_ISSUE;
      ST_ISSUE: if (m_arready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_arready = '0;
    arvalid_d   = arvalid_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          req_arready[pick] = 1'b1;
          arvalid_d         = 1'b1;
          araddr_d          = req_araddr[int'(pick)*ADDR_W +: ADDR_W];
          arlen_d           = req_arlen[int'(pick)*AXI_LEN_W +: AXI_LEN_W];
        end
      end
      ST_ISSUE: begin
        if (m_arready) arvalid_d = 1'b0;
      end
      default: arvalid_d = 1'b0;
    endcase
  end

  always_comb begin
    last_grant_d = grant ? pick : last_grant_q;
    case ({grant, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  sda_gmem_grant_fifo #(
    .GRANT_W (GRANT_W),
    .DEPTH   (MAX_OUT)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (grant),
    .push_data (pick),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // R steering: a beat arriving with nothing outstanding is stalled rather than dropped.
  always_comb begin
    m_rready = !fifo_empty && req_rready[head];
    for (int i = 0; i < NREQ; i++) begin
      req_rvalid[i] = m_rvalid && !fifo_empty && (int'(head) == i);
    end
  end

  assign req_rdata = m_rdata;
  assign req_rresp = m_rresp;
  assign req_rlast = m_rlast;

  assign m_araddr  = araddr_q;
  assign m_arlen   = arlen_q;
  assign m_arvalid = arvalid_q;

endmodule

// File: tb/tb_sda_gmem_read_arbiter.sv
// Directed bench for sda_gmem_read_arbiter (NREQ=2, MAX_OUT=4).
// Inputs change 1ns after the rising edge; outputs are sampled 1-2ns later.
module tb_sda_gmem_read_arbiter;

  localparam int NREQ    = 2;
  localparam int ADDR_W  = 64;
  localparam int DATA_W  = 64;
  localparam int MAX_OUT = 4;

  logic                 clk;
  logic                 reset;
  logic [NREQ*ADDR_W-1:0] req_araddr;
  logic [NREQ*8-1:0]    req_arlen;
  logic [NREQ-1:0]      req_arvalid;
  logic [NREQ-1:0]      req_arready;
  logic [DATA_W-1:0]    req_rdata;
  logic [1:0]           req_rresp;
  logic                 req_rlast;
  logic [NREQ-1:0]      req_rvalid;
  logic [NREQ-1:0]      req_rready;
  logic [ADDR_W-1:0]    m_araddr;
  logic [7:0]           m_arlen;
  logic                 m_arvalid;
  logic                 m_arready;
  logic [DATA_W-1:0]    m_rdata;
  logic [1:0]           m_rresp;
  logic                 m_rlast;
  logic                 m_rvalid;
  logic                 m_rready;

  int n_tests = 0;
  int n_fail  = 0;

  sda_gmem_read_arbiter #(
    .NREQ    (NREQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MAX_OUT (MAX_OUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_araddr  (req_araddr),
    .req_arlen   (req_arlen),
    .req_arvalid (req_arvalid),
    .req_arready (req_arready),
    .req_rdata   (req_rdata),
    .req_rresp   (req_rresp),
    .req_rlast   (req_rlast),
    .req_rvalid  (req_rvalid),
    .req_rready  (req_rready),
    .m_araddr    (m_araddr),
    .m_arlen     (m_arlen),
    .m_arvalid   (m_arvalid),
    .m_arready   (m_arready),
    .m_rdata     (m_rdata),
    .m_rresp     (m_rresp),
    .m_rlast     (m_rlast),
    .m_rvalid    (m_rvalid),
    .m_rready    (m_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [63:0] addr, input logic [7:0] len);
    req_araddr[i*ADDR_W +: ADDR_W] = addr;
    req_arlen[i*8 +: 8]            = len;
  endtask

  task automatic apply_reset();
    reset       = 1'b1;
    req_arvalid = '0;
    req_rready  = '0;
    m_arready   = 1'b0;
    m_rvalid    = 1'b0;
    m_rlast     = 1'b0;
    m_rdata     = '0;
    m_rresp     = 2'b00;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Grant in IDLE, then one ISSUE cycle with m_arready high.
  task automatic do_grant(input string tag, input logic [1:0] exp_rdy,
                          input logic [63:0] exp_addr, input logic [7:0] exp_len,
                          input logic drop);
    #1 chk({tag, "_arready"}, req_arready, exp_rdy);
    tick();
    if (drop) req_arvalid = req_arvalid & ~exp_rdy;
    #1;
    chk({tag, "_arvalid"}, m_arvalid, 1);
    chk({tag, "_araddr"}, m_araddr, exp_addr);
    chk({tag, "_arlen"}, m_arlen, exp_len);
    m_arready = 1'b1;
    #1;
    tick();
    m_arready = 1'b0;
    #1 chk({tag, "_ar_done"}, m_arvalid, 0);
  endtask

  task automatic rbeat(input string tag, input logic [63:0] d, input logic last,
                       input logic [1:0] rdy, input logic [1:0] exp_rv, input logic exp_mr);
    m_rvalid   = 1'b1;
    m_rdata    = d;
    m_rlast    = last;
    m_rresp    = 2'b10;
    req_rready = rdy;
    #1;
    chk({tag, "_rvalid"}, req_rvalid, exp_rv);
    chk({tag, "_mrready"}, m_rready, exp_mr);
    chk({tag, "_rdata"}, req_rdata, d);
    chk({tag, "_rlast"}, req_rlast, last);
    chk({tag, "_rresp"}, req_rresp, 2'b10);
    tick();
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    req_araddr = '0;
    req_arlen  = '0;
    apply_reset();

    // Reset state
    #1;
    chk("rst_arvalid", m_arvalid, 0);
    chk("rst_araddr", m_araddr, 0);
    chk("rst_arlen", m_arlen, 0);
    chk("rst_arready", req_arready, 0);
    chk("rst_empty", dut.fifo_empty, 1);
    chk("rst_cnt", dut.cnt_q, 0);

    // 1. Single request, 4-beat burst to requester 0
    set_req(0, 64'h1000, 8'd3);
    req_arvalid = 2'b01;
    do_grant("single", 2'b01, 64'h1000, 8'd3, 1'b1);
    chk("single_cnt", dut.cnt_q, 1);
    for (int b = 0; b < 4; b++)
      rbeat($sformatf("single_b%0d", b), 64'hA0 + 64'(b), (b == 3), 2'b11, 2'b01, 1'b1);
    #1;
    chk("single_empty", dut.fifo_empty, 1);
    chk("single_cnt0", dut.cnt_q, 0);

    // 2. Contention: both requesters valid from reset
    apply_reset();
    set_req(0, 64'h2000, 8'd1);
    set_req(1, 64'h3000, 8'd0);
    req_arvalid = 2'b11;
    do_grant("rr0", 2'b01, 64'h2000, 8'd1, 1'b0);
    do_grant("rr1", 2'b10, 64'h3000, 8'd0, 1'b0);
    do_grant("rr2", 2'b01, 64'h2000, 8'd1, 1'b0);
    do_grant("rr3", 2'b10, 64'h3000, 8'd0, 1'b0);
    #1;
    chk("rr_full_block", req_arready, 0);
    chk("rr_cnt4", dut.cnt_q, 4);
    req_arvalid = 2'b00;
    rbeat("rr_r0a", 64'h11, 1'b0, 2'b11, 2'b01, 1'b1);
    rbeat("rr_r0b", 64'h12, 1'b1, 2'b11, 2'b01, 1'b1);
    rbeat("rr_r1",  64'h21, 1'b1, 2'b11, 2'b10, 1'b1);
    rbeat("rr_r2a", 64'h13, 1'b0, 2'b11, 2'b01, 1'b1);
    rbeat("rr_r2b", 64'h14, 1'b1, 2'b11, 2'b01, 1'b1);
    rbeat("rr_r3",  64'h22, 1'b1, 2'b11, 2'b10, 1'b1);
    #1 chk("rr_empty", dut.fifo_empty, 1);

    // 3. Outstanding limit with R withheld
    apply_reset();
    set_req(0, 64'h4000, 8'd0);
    req_arvalid = 2'b01;
    for (int g = 0; g < 4; g++)
      do_grant($sformatf("lim_g%0d", g), 2'b01, 64'h4000, 8'd0, 1'b0);
    #1 chk("lim_blk0", req_arready, 0);
    tick();
    chk("lim_blk1", req_arready, 0);
    m_rvalid   = 1'b1;
    m_rlast    = 1'b1;
    req_rready = 2'b01;
    #1;
    chk("lim_pop_mrready", m_rready, 1);
    chk("lim_pop_same", req_arready, 0);
    tick();
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    #1;
    chk("lim_cnt3", dut.cnt_q, 3);
    chk("lim_5th", req_arready, 2'b01);
    do_grant("lim_g4", 2'b01, 64'h4000, 8'd0, 1'b0);
    #1 chk("lim_6th_blk", req_arready, 0);
    chk("lim_cnt4", dut.cnt_q, 4);
    req_arvalid = 2'b00;

    // 4. AR backpressure
    apply_reset();
    set_req(1, 64'h5000, 8'd7);
    set_req(0, 64'h6000, 8'd2);
    req_arvalid = 2'b10;
    #1 chk("bp_grant", req_arready, 2'b10);
    tick();
    req_arvalid = 2'b01;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk($sformatf("bp_vld%0d", c), m_arvalid, 1);
      chk($sformatf("bp_addr%0d", c), m_araddr, 64'h5000);
      chk($sformatf("bp_len%0d", c), m_arlen, 7);
      chk($sformatf("bp_rdy%0d", c), req_arready, 0);
      tick();
    end
    m_arready = 1'b1;
    #1;
    tick();
    m_arready = 1'b0;
    #1;
    chk("bp_done", m_arvalid, 0);
    chk("bp_next", req_arready, 2'b01);
    do_grant("bp_g1", 2'b01, 64'h6000, 8'd2, 1'b1);
    chk("bp_cnt2", dut.cnt_q, 2);

    // 5. R stall on requester 1 mid-burst
    for (int b = 0; b < 3; b++)
      rbeat($sformatf("st_b%0d", b), 64'h50 + 64'(b), 1'b0, 2'b11, 2'b10, 1'b1);
    m_rvalid   = 1'b1;
    m_rdata    = 64'h53;
    m_rlast    = 1'b0;
    req_rready = 2'b01;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("st_hold_mr%0d", c), m_rready, 0);
      chk($sformatf("st_hold_rv%0d", c), req_rvalid, 2'b10);
      chk($sformatf("st_hold_d%0d", c), req_rdata, 64'h53);
      chk($sformatf("st_hold_cnt%0d", c), dut.cnt_q, 2);
      tick();
    end
    for (int b = 3; b < 8; b++)
      rbeat($sformatf("st_b%0d", b), 64'h50 + 64'(b), (b == 7), 2'b11, 2'b10, 1'b1);
    #1 chk("st_pop_cnt", dut.cnt_q, 1);
    for (int b = 0; b < 3; b++)
      rbeat($sformatf("st_r0_b%0d", b), 64'h60 + 64'(b), (b == 2), 2'b11, 2'b01, 1'b1);
    #1 chk("st_empty", dut.fifo_empty, 1);

    // 6. Reset with two bursts outstanding and AR pending
    apply_reset();
    set_req(0, 64'h7000, 8'd0);
    set_req(1, 64'h8000, 8'd1);
    req_arvalid = 2'b01;
    do_grant("mr_g0", 2'b01, 64'h7000, 8'd0, 1'b1);
    req_arvalid = 2'b10;
    #1 chk("mr_g1", req_arready, 2'b10);
    tick();
    req_arvalid = 2'b00;
    #1 chk("mr_pending", m_arvalid, 1);
    chk("mr_cnt2", dut.cnt_q, 2);
    reset = 1'b1;
    tick();
    #1;
    chk("mr_arvalid", m_arvalid, 0);
    chk("mr_araddr", m_araddr, 0);
    chk("mr_empty", dut.fifo_empty, 1);
    chk("mr_cnt0", dut.cnt_q, 0);
    reset       = 1'b0;
    req_arvalid = 2'b11;
    #1 chk("mr_rr_first", req_arready, 2'b01);
    req_arvalid = 2'b00;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
